pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 108 ++++++++++
 tb/tb_pc_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch unit: requests one instruction at pc, holds it until it
// retires, then computes the next pc (sequential, branch/jal, or jalr).
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  CTL_PcSel,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        retire,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        misaligned,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] jalr_sum;
  logic [31:0] next_pc;

  // Target of the held instruction; only consumed in the retire cycle.
  always_comb begin
    jalr_sum = rs1_data + imm;
    case (CTL_PcSel)
      2'b01:   next_pc = pc_q + imm;
      2'b10:   next_pc = {jalr_sum[31:1], 1'b0};
      default: next_pc = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    retire_count_d = retire_count_q;
    misaligned_d   = 1'b0;
    case (state_q)
      REQ: begin
        if (imem_req && imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          state_d        = REQ;
          retire_count_d = retire_count_q + 32'd1;
          // A target that is not word aligned redirects to the trap handler.
          if (next_pc[1:0] != 2'b00) begin
            pc_d         = TRAP_PC;
            misaligned_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= REQ;
      pc_q           <= RESET_PC;
      inst_q         <= 32'd0;
      retire_count_q <= 32'd0;
      misaligned_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      retire_count_q <= retire_count_d;
      misaligned_q   <= misaligned_d;
    end
  end

  // The request is masked while reset is held so nothing is issued before release.
  assign imem_req     = (state_q == REQ) && !rst;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign inst_valid   = (state_q == HOLD);
  assign misaligned   = misaligned_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed reset/handshake sequences, a
// table of jump vectors, and randomized traffic against a transaction model.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [1:0]  ctl_pc_sel;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        retire;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misaligned;
  logic [31:0] retire_count;

  int total;
  int bad;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[9];

  pc_fetch #(
    .RESET_PC(RST_PC),
    .TRAP_PC (TRAP_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .CTL_PcSel   (ctl_pc_sel),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .retire      (retire),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .misaligned  (misaligned),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic scramble();
    ctl_pc_sel = 2'($urandom_range(0, 3));
    imm        = $urandom;
    rs1_data   = $urandom;
  endtask

  // Reference: next pc from the held instruction's control, plain arithmetic.
  task automatic refNext(input logic [31:0] cur, input logic [1:0] sel, input logic [31:0] im,
                         input logic [31:0] rs1, output logic [31:0] nxt, output logic mis);
    logic [31:0] t;
    if (sel == 2'd1)      t = cur + im;
    else if (sel == 2'd2) t = (rs1 + im) & 32'hFFFF_FFFE;
    else                  t = cur + 32'd4;
    mis = (t % 4) != 0;
    nxt = mis ? TRAP_PC : t;
  endtask

  // One full fetch/hold/retire transaction with fixed latencies.
  task automatic applyStimulus(input vec_t v, input logic [31:0] cur_pc, input int exp_count);
    #1;
    checkOutput("tbl_req", imem_req, 1'b1);
    checkOutput("tbl_addr", imem_addr, cur_pc);
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = v.word;
    step();
    imem_rvalid = 1'b0;
    checkOutput("tbl_inst_valid", inst_valid, 1'b1);
    checkOutput("tbl_inst", inst, v.word);
    ctl_pc_sel = v.sel;
    imm        = v.imm;
    rs1_data   = v.rs1;
    retire     = 1'b1;
    step();
    retire = 1'b0;
    scramble();
    checkOutput("tbl_pc", pc, v.exp_pc);
    checkOutput("tbl_mis", misaligned, v.exp_mis);
    checkOutput("tbl_count", retire_count, exp_count);
    checkOutput("tbl_valid_drop", inst_valid, 1'b0);
    step();
    checkOutput("tbl_mis_one_cycle", misaligned, 1'b0);
    checkOutput("tbl_pc_stable", pc, v.exp_pc);
  endtask

  initial begin
    logic [31:0] mpc;
    logic [31:0] mcount;
    logic [31:0] word;
    logic [31:0] nxt;
    logic        mis;

    total = 0;
    bad   = 0;
    rst = 1'b1; ctl_pc_sel = 2'd0; imm = 32'd0; rs1_data = 32'd0; retire = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    vecs[0] = '{2'd1, 32'h0000_0100, 32'h0,         32'h1111_0001, 32'h0000_0100, 1'b0};
    vecs[1] = '{2'd1, 32'hFFFF_FFF0, 32'h0,         32'h1111_0002, 32'h0000_00F0, 1'b0};
    vecs[2] = '{2'd2, 32'h0000_0000, 32'h0000_0203, 32'h1111_0003, TRAP_PC,       1'b1};
    vecs[3] = '{2'd2, 32'h0000_000C, 32'hFFFF_FFF0, 32'h1111_0004, 32'hFFFF_FFFC, 1'b0};
    vecs[4] = '{2'd0, 32'h1234_5677, 32'h0000_0003, 32'h1111_0005, 32'h0000_0000, 1'b0};
    vecs[5] = '{2'd3, 32'h0000_0002, 32'h0000_0001, 32'h1111_0006, 32'h0000_0004, 1'b0};
    vecs[6] = '{2'd1, 32'h0000_0002, 32'h0,         32'h1111_0007, TRAP_PC,       1'b1};
    vecs[7] = '{2'd2, 32'h0000_0010, 32'h0000_0011, 32'h1111_0008, 32'h0000_0020, 1'b0};
    vecs[8] = '{2'd2, 32'hFFFF_FFFC, 32'h0000_0005, 32'h1111_0009, 32'h0000_0000, 1'b0};

    // Reset values while reset is held.
    step();
    step();
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_pc", pc, RST_PC);
    checkOutput("rst_inst_valid", inst_valid, 1'b0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_mis", misaligned, 1'b0);
    checkOutput("rst_count", retire_count, 32'd0);

    // First fetch with minimum latency.
    rst = 1'b0;
    #1;
    checkOutput("first_req", imem_req, 1'b1);
    checkOutput("first_addr", imem_addr, RST_PC);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    checkOutput("wait_req", imem_req, 1'b0);
    checkOutput("wait_valid", inst_valid, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    step();
    imem_rvalid = 1'b0;
    checkOutput("lat_valid", inst_valid, 1'b1);
    checkOutput("lat_inst", inst, 32'h0000_0013);
    checkOutput("hold_req", imem_req, 1'b0);

    // rvalid in HOLD is ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    checkOutput("hold_ign_inst", inst, 32'h0000_0013);
    checkOutput("hold_ign_valid", inst_valid, 1'b1);

    ctl_pc_sel = 2'd0;
    retire     = 1'b1;
    step();
    retire = 1'b0;
    checkOutput("seq_pc", pc, 32'd4);
    checkOutput("seq_count", retire_count, 32'd1);
    checkOutput("seq_valid_drop", inst_valid, 1'b0);
    checkOutput("seq_req", imem_req, 1'b1);

    // Stall in REQ for three cycles; retire and rvalid must be ignored there.
    retire      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_0000;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_req", imem_req, 1'b1);
      checkOutput("stall_addr", imem_addr, 32'd4);
      step();
    end
    checkOutput("req_ign_count", retire_count, 32'd1);
    checkOutput("req_ign_pc", pc, 32'd4);
    checkOutput("req_ign_inst", inst, 32'h0000_0013);
    retire      = 1'b0;
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    step();
    checkOutput("accept_req_low", imem_req, 1'b0);
    step();
    checkOutput("single_accept", imem_req, 1'b0);
    imem_ready = 1'b0;

    // Retire in WAIT is ignored, then reset abandons the outstanding fetch.
    retire = 1'b1;
    step();
    retire = 1'b0;
    checkOutput("wait_ign_count", retire_count, 32'd1);
    checkOutput("wait_ign_pc", pc, 32'd4);
    checkOutput("wait_ign_valid", inst_valid, 1'b0);
    rst = 1'b1;
    step();
    checkOutput("wrst_pc", pc, RST_PC);
    checkOutput("wrst_valid", inst_valid, 1'b0);
    checkOutput("wrst_count", retire_count, 32'd0);
    checkOutput("wrst_inst", inst, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("wrst_req", imem_req, 1'b1);
    checkOutput("wrst_addr", imem_addr, RST_PC);

    // Table of jump/branch targets, chained from the reset pc.
    mpc = RST_PC;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], mpc, i + 1);
      mpc = vecs[i].exp_pc;
    end

    // Randomized latencies and control against the transaction model.
    mcount = 32'd9;
    for (int n = 0; n < 200; n++) begin
      int d;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        retire = 1'($urandom_range(0, 1));
        imem_rvalid = 1'($urandom_range(0, 1));
        step();
        checkOutput("rnd_stall_addr", imem_addr, mpc);
      end
      retire = 1'b0;
      imem_rvalid = 1'b0;
      checkOutput("rnd_req", imem_req, 1'b1);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        retire = 1'($urandom_range(0, 1));
        step();
        checkOutput("rnd_wait_valid", inst_valid, 1'b0);
      end
      retire = 1'b0;
      word = $urandom;
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      step();
      checkOutput("rnd_valid", inst_valid, 1'b1);
      checkOutput("rnd_inst", inst, word);
      d = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        step();
      end
      imem_rvalid = 1'b0;
      checkOutput("rnd_inst_hold", inst, word);
      ctl_pc_sel = 2'($urandom_range(0, 3));
      imm = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 15)) - 32'd8) : $urandom;
      rs1_data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4095)) : $urandom;
      refNext(mpc, ctl_pc_sel, imm, rs1_data, nxt, mis);
      retire = 1'b1;
      step();
      retire = 1'b0;
      scramble();
      mpc    = nxt;
      mcount = mcount + 32'd1;
      checkOutput("rnd_pc", pc, mpc);
      checkOutput("rnd_mis", misaligned, mis);
      checkOutput("rnd_count", retire_count, mcount);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
